// File: rtl/wrp_pkg.sv
// Shared defaults for the wrapper-side FIFOs (input and return path).
package wrp_pkg;

  localparam int unsigned WRP_WIDTH        = 64;
  localparam int unsigned WRP_DEPTH        = 32;
  localparam int unsigned WRP_AVAIL_THRESH = WRP_DEPTH / 2;

  // Fill counter needs one extra bit to represent the full state (0..depth).
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wrp_dout_sdpram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read. Contents not reset.
module wrp_dout_sdpram #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wrp_dout_sfifo.sv
// Return-path FIFO: accepts AXI-stream beats and presents them to the wrapper via pop/valid.
module wrp_dout_sfifo
  import wrp_pkg::*;
#(
  parameter int unsigned WIDTH        = WRP_WIDTH,
  parameter int unsigned DEPTH        = WRP_DEPTH,
  parameter int unsigned AVAIL_THRESH = WRP_AVAIL_THRESH
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          axi_vld,
  input  logic [WIDTH-1:0]              axi_dat,
  output logic                          axi_rdy,
  output logic                          wrp_avail,
  input  logic                          wrp_re,
  output logic                          wrp_rvld,
  output logic [WIDTH-1:0]              wrp_rd,
  output logic [cnt_width(DEPTH)-1:0]   wrp_cnt,
  output logic                          wrp_udf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] ram_rdata;
  logic             wr;
  logic             rd;
  logic             empty;

  assign empty = (wrp_cnt == '0);
  assign wr    = axi_vld & axi_rdy;
  assign rd    = wrp_re & ~empty;

  always_comb begin
    cnt_nxt = wrp_cnt + CW'(wr) - CW'(rd);
  end

  wrp_dout_sdpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr),
    .waddr (wptr),
    .wdata (axi_dat),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  // Flags are registered from the next count so they line up with wrp_cnt.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wptr      <= '0;
      rptr      <= '0;
      wrp_cnt   <= '0;
      axi_rdy   <= 1'b0;
      wrp_avail <= 1'b0;
      wrp_rvld  <= 1'b0;
      wrp_rd    <= '0;
      wrp_udf   <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + AW'(1);
      end
      if (rd) begin
        rptr   <= rptr + AW'(1);
        wrp_rd <= ram_rdata;
      end
      wrp_rvld  <= rd;
      wrp_cnt   <= cnt_nxt;
      axi_rdy   <= (cnt_nxt < CW'(DEPTH));
      wrp_avail <= (cnt_nxt >= CW'(AVAIL_THRESH));
      if (wrp_re && empty) begin
        wrp_udf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wrp_dout_sfifo.sv
// Scenario bench for wrp_dout_sfifo with a cycle model and data scoreboard.
module tb_wrp_dout_sfifo;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned THRESH = 16;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic             clk;
  logic             srst;
  logic             axi_vld;
  logic [WIDTH-1:0] axi_dat;
  logic             axi_rdy;
  logic             wrp_avail;
  logic             wrp_re;
  logic             wrp_rvld;
  logic [WIDTH-1:0] wrp_rd;
  logic [CW-1:0]    wrp_cnt;
  logic             wrp_udf;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  // Reference model state (advanced on negedge, between active edges)
  logic [WIDTH-1:0] sb_q[$];
  int               mcnt      = 0;
  logic             exp_rdy   = 1'b0;
  logic             exp_avail = 1'b0;
  logic             exp_rvld  = 1'b0;
  logic             exp_udf   = 1'b0;

  wrp_dout_sfifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AVAIL_THRESH (THRESH)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .axi_vld   (axi_vld),
    .axi_dat   (axi_dat),
    .axi_rdy   (axi_rdy),
    .wrp_avail (wrp_avail),
    .wrp_re    (wrp_re),
    .wrp_rvld  (wrp_rvld),
    .wrp_rd    (wrp_rd),
    .wrp_cnt   (wrp_cnt),
    .wrp_udf   (wrp_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    logic             w;
    logic             r;
    logic [WIDTH-1:0] exp_d;
    if (srst) begin
      sb_q.delete();
      mcnt      = 0;
      exp_rdy   = 1'b0;
      exp_avail = 1'b0;
      exp_rvld  = 1'b0;
      exp_udf   = 1'b0;
    end else begin
      n_checks++;
      if (wrp_cnt !== CW'(mcnt)) begin
        n_fail++;
        $display("FAIL mon_cnt t=%0t: got %0d expected %0d", $time, wrp_cnt, mcnt);
      end
      n_checks++;
      if (axi_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL mon_rdy t=%0t: got %b expected %b", $time, axi_rdy, exp_rdy);
      end
      n_checks++;
      if (wrp_avail !== exp_avail) begin
        n_fail++;
        $display("FAIL mon_avail t=%0t: got %b expected %b", $time, wrp_avail, exp_avail);
      end
      n_checks++;
      if (wrp_rvld !== exp_rvld) begin
        n_fail++;
        $display("FAIL mon_rvld t=%0t: got %b expected %b", $time, wrp_rvld, exp_rvld);
      end
      n_checks++;
      if (wrp_udf !== exp_udf) begin
        n_fail++;
        $display("FAIL mon_udf t=%0t: got %b expected %b", $time, wrp_udf, exp_udf);
      end
      if (wrp_rvld === 1'b1) begin
        n_pops++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL mon_data t=%0t: got %0h expected no data (scoreboard empty)",
                   $time, wrp_rd);
        end else begin
          exp_d = sb_q.pop_front();
          if (wrp_rd !== exp_d) begin
            n_fail++;
            $display("FAIL mon_data t=%0t: got %0h expected %0h", $time, wrp_rd, exp_d);
          end
        end
      end
      w = axi_vld && exp_rdy;
      r = wrp_re && (mcnt != 0);
      if (wrp_re && mcnt == 0) exp_udf = 1'b1;
      if (w) sb_q.push_back(axi_dat);
      mcnt      = mcnt + int'(w) - int'(r);
      exp_rvld  = r;
      exp_rdy   = (mcnt < DEPTH);
      exp_avail = (mcnt >= THRESH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({axi_rdy, wrp_avail, wrp_rvld, wrp_udf} !== 4'b0 || wrp_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got rdy=%b avail=%b rvld=%b udf=%b cnt=%0d expected all 0",
               axi_rdy, wrp_avail, wrp_rvld, wrp_udf, wrp_cnt);
    end
    tick();
    srst = 1'b0;
    n_checks++;
    if (axi_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdy_pre: got %b expected 0", axi_rdy);
    end
    tick();
    n_checks++;
    if (axi_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy_post: got %b expected 1", axi_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      axi_vld = 1'b1;
      axi_dat = WIDTH'(5 + i);
      tick();
    end
    axi_vld = 1'b0;
    wrp_re  = 1'b1;
    wrp_re  = 1'b1;
    tick();
    wrp_re = 1'b0;
    #2 srst = 1'b1;
    #1;
    n_checks++;
    if ({axi_rdy, wrp_avail, wrp_rvld, wrp_udf} !== 4'b0 || wrp_cnt !== '0 || wrp_rd !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got rdy=%b avail=%b rvld=%b udf=%b cnt=%0d rd=%0h expected 0",
               axi_rdy, wrp_avail, wrp_rvld, wrp_udf, wrp_cnt, wrp_rd);
    end
    tick();
    srst = 1'b0;
    tick();
    n_checks++;
    if (axi_rdy !== 1'b1 || wrp_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b cnt=%0d expected rdy=1 cnt=0", axi_rdy, wrp_cnt);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      axi_vld = 1'b1;
      axi_dat = WIDTH'(i);
      tick();
      if (i == 14) begin
        n_checks++;
        if (wrp_avail !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_avail15: got %b expected 0", wrp_avail);
        end
      end
      if (i == 15) begin
        n_checks++;
        if (wrp_avail !== 1'b1) begin
          n_fail++;
          $display("FAIL fill_avail16: got %b expected 1", wrp_avail);
        end
      end
    end
    n_checks++;
    if (axi_rdy !== 1'b0 || wrp_cnt !== CW'(32)) begin
      n_fail++;
      $display("FAIL fill_full: got rdy=%b cnt=%0d expected rdy=0 cnt=32", axi_rdy, wrp_cnt);
    end
    axi_dat = WIDTH'(32);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wrp_cnt !== CW'(32) || axi_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_hold: got cnt=%0d rdy=%b expected cnt=32 rdy=0", wrp_cnt, axi_rdy);
      end
    end
    axi_vld = 1'b0;
  endtask

  task automatic test_drain();
    wrp_re = 1'b1;
    for (int k = 0; k < 33; k++) begin
      tick();
      if (k == 0) begin
        n_checks++;
        if (axi_rdy !== 1'b1 || wrp_rvld !== 1'b1 || wrp_rd !== WIDTH'(0)) begin
          n_fail++;
          $display("FAIL drain_first: got rdy=%b rvld=%b rd=%0h expected 1 1 0",
                   axi_rdy, wrp_rvld, wrp_rd);
        end
      end
    end
    wrp_re = 1'b0;
    n_checks++;
    if (wrp_rvld !== 1'b0 || wrp_udf !== 1'b1 || wrp_rd !== WIDTH'(31)) begin
      n_fail++;
      $display("FAIL drain_udf: got rvld=%b udf=%b rd=%0h expected 0 1 1f",
               wrp_rvld, wrp_udf, wrp_rd);
    end
    tick();
    tick();
    n_checks++;
    if (wrp_udf !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_udf_sticky: got %b expected 1", wrp_udf);
    end
  endtask

  task automatic test_steady();
    for (int i = 0; i < 16; i++) begin
      axi_vld = 1'b1;
      axi_dat = WIDTH'(100 + i);
      tick();
    end
    wrp_re = 1'b1;
    for (int i = 0; i < 64; i++) begin
      axi_dat = WIDTH'(200 + i);
      tick();
      n_checks++;
      if (wrp_cnt !== CW'(16) || wrp_avail !== 1'b1) begin
        n_fail++;
        $display("FAIL steady_cnt: got cnt=%0d avail=%b expected 16 1", wrp_cnt, wrp_avail);
      end
    end
    axi_vld = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    wrp_re = 1'b0;
    tick();
    tick();
    n_checks++;
    if (sb_q.size() != 0 || wrp_cnt !== '0) begin
      n_fail++;
      $display("FAIL steady_drain: got left=%0d cnt=%0d expected 0 0", sb_q.size(), wrp_cnt);
    end
  endtask

  task automatic test_wrap();
    int next;
    int base;
    int cyc;
    do_reset();
    base = n_pops;
    next = 0;
    cyc  = 0;
    while (next < 200 && cyc < 3000) begin
      axi_dat = WIDTH'(next);
      axi_vld = ($urandom_range(0, 3) != 0);
      wrp_re  = ($urandom_range(0, 1) == 1) && (wrp_cnt != '0);
      if (axi_vld && axi_rdy) next++;
      tick();
      cyc++;
    end
    axi_vld = 1'b0;
    n_checks++;
    if (next != 200) begin
      n_fail++;
      $display("FAIL wrap_push_budget: got %0d pushed expected 200", next);
    end
    cyc = 0;
    while ((n_pops - base) < 200 && cyc < 500) begin
      wrp_re = (wrp_cnt != '0);
      tick();
      cyc++;
    end
    wrp_re = 1'b0;
    tick();
    n_checks++;
    if ((n_pops - base) != 200 || wrp_udf !== 1'b0 || wrp_rd !== WIDTH'(199)) begin
      n_fail++;
      $display("FAIL wrap_result: got pops=%0d udf=%b last=%0h expected 200 0 c7",
               n_pops - base, wrp_udf, wrp_rd);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 10; i++) begin
      axi_vld = 1'b1;
      axi_dat = WIDTH'(300 + i);
      tick();
    end
    axi_vld = 1'b0;
    wrp_re  = 1'b1;
    tick();
    wrp_re = 1'b0;
    n_checks++;
    if (wrp_rvld !== 1'b1 || wrp_cnt !== CW'(9)) begin
      n_fail++;
      $display("FAIL midrst_pre: got rvld=%b cnt=%0d expected 1 9", wrp_rvld, wrp_cnt);
    end
    #2 srst = 1'b1;
    #1;
    n_checks++;
    if (wrp_rvld !== 1'b0 || wrp_cnt !== '0 || wrp_avail !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got rvld=%b cnt=%0d avail=%b expected 0 0 0",
               wrp_rvld, wrp_cnt, wrp_avail);
    end
    tick();
    srst = 1'b0;
    tick();
    axi_vld = 1'b1;
    axi_dat = WIDTH'(8'hA5);
    tick();
    axi_vld = 1'b0;
    wrp_re  = 1'b1;
    tick();
    wrp_re = 1'b0;
    n_checks++;
    if (wrp_rvld !== 1'b1 || wrp_rd !== WIDTH'(8'hA5)) begin
      n_fail++;
      $display("FAIL midrst_fresh: got rvld=%b rd=%0h expected 1 a5", wrp_rvld, wrp_rd);
    end
    tick();
    n_checks++;
    if (wrp_cnt !== '0 || wrp_rvld !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_empty: got cnt=%0d rvld=%b expected 0 0", wrp_cnt, wrp_rvld);
    end
  endtask

  initial begin
    srst    = 1'b1;
    axi_vld = 1'b0;
    axi_dat = '0;
    wrp_re  = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_steady();
    test_wrap();
    test_mid_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
